// File: rtl/cpu_types_pkg.sv
// Shared CPU types: mult/div opcodes, sequencer states
// and the EX->MEM bundle fields produced by the mult/div unit.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_t;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_CALC,
    MD_FIXUP,
    MD_DONE
  } md_state_t;

  typedef struct packed {
    logic              md_done;
    logic              md_div_zero;
    logic [WORD_W-1:0] md_hi;
    logic [WORD_W-1:0] md_lo;
  } execute_t;

  function automatic logic md_is_signed(md_op_t o);
    return (o == MD_MULT) || (o == MD_DIV);
  endfunction

endpackage

// File: rtl/mult_div_ctrl_datapath.sv
// Mult/div datapath: accumulator, shift-add / restoring-divide
// step, sign fixup and committed HI/LO. Early-out: MULT_EARLY_OUT_EN.
import cpu_types_pkg::*;

module md_datapath #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ld_i,
  input  logic             dz_i,
  input  logic             step_i,
  input  logic             early_i,
  input  logic             fix_i,
  input  md_op_t           op_i,
  input  logic [WIDTH-1:0] rs_i,
  input  logic [WIDTH-1:0] rt_i,
  input  logic [CNT_W-1:0] cnt_i,
  output logic             rem_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             dz_o
);

  localparam int W2 = 2 * WIDTH;

  logic [W2-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] mcd_q;
  logic             mul_q, neg_q, rneg_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             dz_q;

  logic             sgn;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   sum;
  logic [W2-1:0]    mstep, dstep, sh, prod;
  logic             ge;
  logic [WIDTH-1:0] quot, rem;

  // Operand magnitudes and one iteration of either algorithm
  always_comb begin
    sgn   = md_is_signed(op_i);
    a_mag = (sgn && rs_i[WIDTH-1]) ? -rs_i : rs_i;
    b_mag = (sgn && rt_i[WIDTH-1]) ? -rt_i : rt_i;
    sum   = {1'b0, acc_q[W2-1:WIDTH]}
          + (acc_q[0] ? {1'b0, mcd_q} : '0);
    mstep = {sum, acc_q[WIDTH-1:1]};
    sh    = {acc_q[W2-2:0], 1'b0};
    ge    = acc_q[W2-1] || (sh[W2-1:WIDTH] >= mcd_q);
    dstep = sh;
    if (ge) begin
      dstep[W2-1:WIDTH] = sh[W2-1:WIDTH] - mcd_q;
      dstep[0]          = 1'b1;
    end
    acc_d = acc_q;
    if (step_i) begin
      if (!mul_q)       acc_d = dstep;
      else if (early_i) acc_d = mstep >> cnt_i;
      else              acc_d = mstep;
    end
    prod = neg_q ? -acc_q : acc_q;
    quot = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem  = rneg_q ? -acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];
  end

`ifdef MULT_EARLY_OUT_EN
  localparam logic [WIDTH-1:0] ONE = 1;
  logic [WIDTH-1:0] left_mask;
  // Multiplier bits still to be consumed after this step
  always_comb begin
    left_mask  = (ONE << cnt_i) - ONE;
    rem_zero_o = mul_q &&
      (((acc_q[WIDTH-1:0] >> 1) & left_mask) == '0);
  end
`else
  assign rem_zero_o = 1'b0;
`endif

  // Operand latch, iteration and commit of HI/LO
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      acc_q  <= '0;
      mcd_q  <= '0;
      mul_q  <= 1'b0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      dz_q   <= 1'b0;
    end else begin
      acc_q <= acc_d;
      if (ld_i) begin
        mul_q  <= ~op_i[1];
        acc_q  <= {{WIDTH{1'b0}}, op_i[1] ? a_mag : b_mag};
        mcd_q  <= op_i[1] ? b_mag : a_mag;
        neg_q  <= sgn && (rs_i[WIDTH-1] ^ rt_i[WIDTH-1]);
        rneg_q <= sgn && rs_i[WIDTH-1];
        dz_q   <= 1'b0;
      end
      if (dz_i) begin
        hi_q <= rs_i;
        lo_q <= '1;
        dz_q <= 1'b1;
      end
      if (fix_i) begin
        if (mul_q) begin
          hi_q <= prod[W2-1:WIDTH];
          lo_q <= prod[WIDTH-1:0];
        end else begin
          hi_q <= rem;
          lo_q <= quot;
        end
      end
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;
  assign dz_o = dz_q;

endmodule

// File: rtl/mult_div_ctrl.sv
// Iterative mult/div sequencer at EX: stalls the pipe while
// busy, presents HI/LO on done. Early-out: MULT_EARLY_OUT_EN.
import cpu_types_pkg::*;

module mult_div_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             start,
  input  md_op_t           op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             flush,
  input  logic             adv,
  output logic             stall_req,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  md_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ld, dz, step, early, fix;
  logic             rem_zero;

  // State and iteration counter
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and datapath controls; flush overrides all
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ld      = 1'b0;
    dz      = 1'b0;
    step    = 1'b0;
    early   = 1'b0;
    fix     = 1'b0;
    if (flush) begin
      state_d = MD_IDLE;
    end else begin
      unique case (state_q)
        MD_IDLE: begin
          if (start) begin
            if (op[1] && (rt_val == '0)) begin
              dz      = 1'b1;
              state_d = MD_DONE;
            end else begin
              ld      = 1'b1;
              cnt_d   = CNT_W'(WIDTH - 1);
              state_d = MD_CALC;
            end
          end
        end
        MD_CALC: begin
          step  = 1'b1;
          early = rem_zero;
          cnt_d = cnt_q - CNT_W'(1);
          if ((cnt_q == '0) || early) begin
            cnt_d   = '0;
            state_d = MD_FIXUP;
          end
        end
        MD_FIXUP: begin
          fix     = 1'b1;
          state_d = MD_DONE;
        end
        MD_DONE: begin
          if (adv) state_d = MD_IDLE;
        end
        default: state_d = MD_IDLE;
      endcase
    end
  end

  assign stall_req = ((state_q == MD_IDLE) && start && !flush)
                   || (state_q == MD_CALC)
                   || (state_q == MD_FIXUP);
  assign done = (state_q == MD_DONE);

  md_datapath #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_dp (
    .CLK        (CLK),
    .nRST       (nRST),
    .ld_i       (ld),
    .dz_i       (dz),
    .step_i     (step),
    .early_i    (early),
    .fix_i      (fix),
    .op_i       (op),
    .rs_i       (rs_val),
    .rt_i       (rt_val),
    .cnt_i      (cnt_q),
    .rem_zero_o (rem_zero),
    .hi_o       (hi),
    .lo_o       (lo),
    .dz_o       (div_zero)
  );

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Scoreboard bench for mult_div_ctrl: reference results are
// queued at issue and compared when done rises.
import cpu_types_pkg::*;

module tb_mult_div_ctrl;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        start = 1'b0;
  md_op_t      op = MD_MULT;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        flush = 1'b0;
  logic        adv = 1'b1;
  logic        stall_req, done, div_zero;
  logic [31:0] hi, lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  mult_div_ctrl #(.WIDTH(32)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .start     (start),
    .op        (op),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .flush     (flush),
    .adv       (adv),
    .stall_req (stall_req),
    .done      (done),
    .hi        (hi),
    .lo        (lo),
    .div_zero  (div_zero)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(md_op_t o, logic [31:0] a,
                                 logic [31:0] b);
    exp_t e;
    logic signed [63:0] p;
    logic [63:0] u;
    logic signed [31:0] sa, sb2;
    e.dz = 1'b0;
    sa   = a;
    sb2  = b;
    case (o)
      MD_MULT: begin
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      MD_MULTU: begin
        u = {32'd0, a} * {32'd0, b};
        e.hi = u[63:32];
        e.lo = u[31:0];
      end
      MD_DIV: begin
        if (b == 0) begin
          e.hi = a; e.lo = '1; e.dz = 1'b1;
        end else if (a == 32'h8000_0000 && b == '1) begin
          e.hi = 0; e.lo = 32'h8000_0000;
        end else begin
          e.lo = sa / sb2;
          e.hi = sa % sb2;
        end
      end
      default: begin
        if (b == 0) begin
          e.hi = a; e.lo = '1; e.dz = 1'b1;
        end else begin
          e.lo = a / b;
          e.hi = a % b;
        end
      end
    endcase
    return e;
  endfunction

  function automatic int exp_lat(md_op_t o, logic [31:0] b);
    int lat;
    logic [31:0] mb;
    lat = 34;
    mb  = (o == MD_MULT && b[31]) ? -b : b;
    if (o[1] && b == 0) lat = 1;
`ifdef MULT_EARLY_OUT_EN
    if (!o[1]) begin
      lat = 3;
      for (int i = 0; i < 32; i++)
        if (mb[i]) lat = i + 3;
    end
`else
    if (mb == 32'hFFFF_FFFF) lat = 34;
`endif
    return lat;
  endfunction

  task automatic run_op(input md_op_t o, input logic [31:0] a,
                        input logic [31:0] b);
    exp_t e, g;
    int   lat, cyc;
    bit   busy_ok;
    sb.push_back(model(o, a, b));
    lat = exp_lat(o, b);
    op = o; rs_val = a; rt_val = b; start = 1'b1;
    #1;
    chk("stall_c0", 64'(stall_req), 64'd1);
    cyc = 0;
    busy_ok = 1'b1;
    do begin
      @(posedge CLK); #1;
      start = 1'b0;
      cyc++;
      if (!done && !stall_req) busy_ok = 1'b0;
    end while (!done && cyc < 200);
    chk("latency", 64'(cyc), 64'(lat));
    chk("stall_busy", 64'(busy_ok), 64'd1);
    chk("stall_done", 64'(stall_req), 64'd0);
    e = sb.pop_front();
    if (done) begin
      g.hi = hi; g.lo = lo; g.dz = div_zero;
      chk("hi", 64'(g.hi), 64'(e.hi));
      chk("lo", 64'(g.lo), 64'(e.lo));
      chk("div_zero", 64'(g.dz), 64'(e.dz));
    end else begin
      chk("done_timeout", 64'd0, 64'd1);
    end
    last_hi = e.hi;
    last_lo = e.lo;
    @(posedge CLK); #1;
    chk("idle_after", 64'(done), 64'd0);
  endtask

  initial begin
    #12;
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_dz", 64'(div_zero), 64'd0);
    chk("rst_stall", 64'(stall_req), 64'd0);
    @(negedge CLK) nRST = 1'b1;
    @(posedge CLK); #1;

    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(MD_MULT, -32'd3, 32'd7);
    run_op(MD_DIV, -32'd7, 32'd2);
    run_op(MD_DIVU, 32'd7, 32'd2);
    run_op(MD_DIV, 32'd5, 32'd0);
    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(MD_MULTU, 32'd12345, 32'd3);
    run_op(MD_MULT, 32'd99, 32'd0);
    run_op(MD_MULT, 32'd5, -32'd9);
    run_op(MD_DIVU, 32'hFFFF_FFFF, 32'h8000_0001);
    for (int i = 0; i < 6; i++)
      run_op(md_op_t'(i % 4), $urandom, $urandom);

    // start and flush together in IDLE: nothing begins
    op = MD_DIVU; rs_val = 32'd100; rt_val = 32'd7;
    start = 1'b1; flush = 1'b1;
    #1;
    chk("sf_stall", 64'(stall_req), 64'd0);
    @(posedge CLK); #1;
    start = 1'b0; flush = 1'b0;
    #1;
    chk("sf_idle", 64'(stall_req), 64'd0);

    // flush at cycle 10 of a divide
    start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge CLK); #1;
      start = 1'b0;
    end
    flush = 1'b1;
    @(posedge CLK); #1;
    flush = 1'b0;
    chk("fl_stall", 64'(stall_req), 64'd0);
    chk("fl_done", 64'(done), 64'd0);
    chk("fl_hi", 64'(hi), 64'(last_hi));
    chk("fl_lo", 64'(lo), 64'(last_lo));
    run_op(MD_DIVU, 32'd100, 32'd7);

    // async reset in the middle of a multiply
    op = MD_MULT; rs_val = 32'd1234; rt_val = 32'd5678;
    start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(posedge CLK); #1;
      start = 1'b0;
    end
    nRST = 1'b0;
    #1;
    chk("ar_hi", 64'(hi), 64'd0);
    chk("ar_lo", 64'(lo), 64'd0);
    chk("ar_done", 64'(done), 64'd0);
    chk("ar_stall", 64'(stall_req), 64'd0);
    chk("ar_dz", 64'(div_zero), 64'd0);
    @(negedge CLK) nRST = 1'b1;
    @(posedge CLK); #1;
    chk("ar_idle", 64'(stall_req), 64'd0);
    run_op(MD_MULT, 32'h8000_0000, 32'h8000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_div_ctrl.md
Name: mult_div_ctrl

Overview:
Sequencer for an iterative multiply/divide unit attached to the execute stage. It accepts MULT/MULTU/DIV/DIVU from the EX stage and runs a 1-bit-per-cycle shift-add multiply or restoring divide. While busy it raises a stall request to the hazard logic, and it presents HI/LO results when done. A flush aborts the operation.

Parameters:
WIDTH, 32, operand width (word_t width)
CNT_W, $clog2(WIDTH), iteration counter width

Ports:
CLK  input  1  system clock
nRST  input  1  asynchronous active-low reset
start  input  1  EX stage holds a valid mult/div instruction
op  input  md_op_t(2)  MD_MULT, MD_MULTU, MD_DIV, MD_DIVU
rs_val  input  WIDTH  multiplicand / dividend
rt_val  input  WIDTH  multiplier / divisor
flush  input  1  pipeline flush; abort current operation
adv  input  1  EX stage advancing this cycle (ihit and no other stall)
stall_req  output  1  hold the pipeline at EX
done  output  1  result valid on hi/lo
hi  output  WIDTH  product high word / remainder
lo  output  WIDTH  product low word / quotient
div_zero  output  1  completed division had rt_val == 0

Behaviour:
- Reset (async, nRST low): state IDLE; hi, lo = 0; done = 0; div_zero = 0; counter = 0. Applies mid-operation and discards all partial state.
- States: IDLE, CALC, FIXUP, DONE.
- IDLE:
  - On start & ~flush: latch op, operand magnitudes (abs() for signed ops, raw for unsigned) and result sign bits. Clear accumulator; counter = WIDTH-1; go to CALC.
  - Division with rt_val == 0 goes straight to DONE: hi = rs_val, lo = all-ones, div_zero = 1.
- CALC, one iteration per cycle:
  - Multiply: if multiplier LSB, add multiplicand into upper half of 2*WIDTH accumulator; shift right 1.
  - Divide: shift {rem,quot} left 1; if rem >= divisor, subtract and set quot LSB.
  - Counter decrements; at counter == 0 go to FIXUP.
- FIXUP (1 cycle):
  - Signed multiply: negate 64-bit product if operand signs differ.
  - Signed divide: negate quotient if signs differ; remainder takes the dividend's sign.
  - Load hi/lo registers; go to DONE.
- DONE: done = 1, hi/lo stable. On adv go to IDLE. start is ignored until IDLE is re-entered.
- Latency: start seen in IDLE at cycle 0 gives done in cycle WIDTH+2 (34 for WIDTH=32). Divide-by-zero gives done in cycle 1.
- stall_req = (state==IDLE & start & ~flush) | state==CALC | state==FIXUP. It is combinational and never asserted in DONE.
- flush has priority over everything except reset. In any state it forces IDLE next cycle. hi/lo/div_zero keep their last committed values; done drops next cycle.
- Simultaneous flush & start in IDLE: no operation starts and stall_req = 0.
- Arithmetic is modulo 2^WIDTH, with no overflow flag:
  - INT_MIN/-1: lo = 0x80000000, hi = 0.
  - INT_MIN*INT_MIN (signed): hi = 0x40000000, lo = 0.
- div_zero is cleared on every new start.

Optional Feature:
MULT_EARLY_OUT_EN
- Defined: in CALC during a multiply, if the remaining unshifted multiplier bits are all zero, shift the accumulator right by the remaining count in one cycle and go to FIXUP. Latency becomes (index of highest set multiplier magnitude bit)+3 cycles. A zero multiplier goes CALC→FIXUP on the first CALC cycle. Divide is unaffected.
- Undefined: fixed WIDTH+2 latency for all non-div-by-zero ops.

Decomposition:
- Shared package (cpu_types_pkg): md_op_t enum (MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3) and md_state_t.
- Mult/div fields that EX forwards to MEM belong in the structs package execute_t.
- One sub-module is natural: md_datapath, holding the accumulator, add/subtract/shift and sign fixup under control signals from the FSM in mult_div_ctrl.

Test Plan:
- MULTU 0xFFFFFFFF*0xFFFFFFFF, adv held 1 → stall_req 1 for cycles 0-33; done at cycle 34 with hi=0xFFFFFFFE, lo=0x00000001; IDLE at cycle 35.
- MULT -3*7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV -7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 → lo=3, hi=1.
- DIV 5/0 → done at cycle 1, div_zero=1, hi=5, lo=0xFFFFFFFF, stall_req high only in cycle 0.
- DIVU 100/7 with flush at cycle 10 → IDLE at cycle 11, stall_req 0, hi/lo keep prior values; a new DIVU 100/7 then gives lo=14, hi=2.
- nRST pulsed low at cycle 5 of a MULT → all outputs 0 asynchronously; later MULT INT_MIN*INT_MIN → hi=0x40000000, lo=0.
- With MULT_EARLY_OUT_EN: MULTU 12345*3 → done at cycle 4, lo=37035, hi=0. Without it the same op finishes at cycle 34.
